// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data-memory port.
// A 16-byte register window holds TXDATA, STATUS, DIV and CTRL, in that order.
// TXDATA pushes bytes into a small circular FIFO.
// A four-state serializer drains the FIFO using a programmable baud divider.
// Optional feature macro: MMIO_UART_IRQ_EN.
// When it is defined, the block gains irq_o and a CTRL irq_enable bit.
// When it is undefined, CTRL reads as zero and writes to it are ignored.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  data_mem_we_i,
   input  logic [31:0] data_mem_address_i,
   input  logic [31:0] data_mem_write_i,
   output logic [31:0] data_mem_read_o,
`ifdef MMIO_UART_IRQ_EN
   output logic        irq_o,
`endif
   output logic        tx_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      DIV_RESET = 16'(CLK_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // ---------------- address decode ----------------
   logic       sel;
   logic [1:0] reg_off;
   logic       wr_en;
   logic       push_req;
   logic       ovf_clr;
   logic       div_wr_lo;
   logic       div_wr_hi;

   assign sel       = (data_mem_address_i[31:4] == BASE_ADDR[31:4]);
   assign reg_off   = data_mem_address_i[3:2];
   assign wr_en     = sel & (|data_mem_we_i);
   assign push_req  = wr_en & (reg_off == 2'd0) & data_mem_we_i[0];
   assign ovf_clr   = wr_en & (reg_off == 2'd1) & data_mem_we_i[0] & data_mem_write_i[3];
   assign div_wr_lo = wr_en & (reg_off == 2'd2) & data_mem_we_i[0];
   assign div_wr_hi = wr_en & (reg_off == 2'd2) & data_mem_we_i[1];

   // Byte-offset bits and the upper write lanes have no meaning in this window.
   logic unused_bits;
   assign unused_bits = ^{data_mem_address_i[1:0], data_mem_write_i[31:16]};

   // ---------------- TX FIFO ----------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             full;
   logic             empty;
   logic             push_ok;
   logic             pop;

   assign full    = (count_reg == DEPTH_CNT);
   assign empty   = (count_reg == '0);
   assign push_ok = push_req & ~full;

   // FIFO storage. After reset the contents are stale but unreachable, because the pointers clear.
   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr_reg] <= data_mem_write_i[7:0];
   end

   // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------- control registers ----------------
   logic        ovf_reg;
   logic [15:0] div_reg;
   logic [15:0] eff_div;

   assign eff_div = (div_reg < 16'd2) ? 16'd2 : div_reg;

   // Sticky overflow and the baud divider. A push that meets a full FIFO is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_reg <= 1'b0;
         div_reg <= DIV_RESET;
      end else begin
         if (push_req & full)
            ovf_reg <= 1'b1;
         else if (ovf_clr)
            ovf_reg <= 1'b0;
         if (div_wr_lo)
            div_reg[7:0] <= data_mem_write_i[7:0];
         if (div_wr_hi)
            div_reg[15:8] <= data_mem_write_i[15:8];
      end
   end

   // ---------------- serializer ----------------
   state_t      state_reg;
   state_t      state_next;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt_reg;
   logic [15:0] baud_cnt_reg;
   logic        tx_reg;
   logic        baud_done;
   logic        baud_load;
   logic        shift_load;
   logic        shift_en;
   logic        bit_clr;
   logic        bit_inc;
   logic        tx_next;
   logic        busy;

   assign baud_done = (baud_cnt_reg == 16'd0);
   assign busy      = (state_reg != IDLE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic. STOP chains straight into START when more data is waiting.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (!empty) state_next = START;
         START: if (baud_done) state_next = DATA;
         DATA:  if (baud_done && bit_cnt_reg == 3'd7) state_next = STOP;
         STOP:  if (baud_done) state_next = empty ? IDLE : START;
         default: state_next = IDLE;
      endcase
   end

   // Datapath controls, plus the line level for the next cycle. tx_o is a flop, so it stays glitch-free.
   always_comb begin
      pop        = 1'b0;
      baud_load  = 1'b0;
      shift_load = 1'b0;
      shift_en   = 1'b0;
      bit_clr    = 1'b0;
      bit_inc    = 1'b0;
      tx_next    = 1'b1;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_load = 1'b1;
               baud_load  = 1'b1;
               tx_next    = 1'b0;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (baud_done) begin
               baud_load = 1'b1;
               bit_clr   = 1'b1;
               tx_next   = shift_reg[0];
            end
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (baud_done) begin
               baud_load = 1'b1;
               if (bit_cnt_reg == 3'd7) begin
                  tx_next = 1'b1;
               end else begin
                  shift_en = 1'b1;
                  bit_inc  = 1'b1;
                  tx_next  = shift_reg[1];
               end
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (baud_done && !empty) begin
               pop        = 1'b1;
               shift_load = 1'b1;
               baud_load  = 1'b1;
               tx_next    = 1'b0;
            end
         end
         default: tx_next = 1'b1;
      endcase
   end

   // Shift register, bit counter and baud counter. The divider is sampled only at bit boundaries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         baud_cnt_reg <= '0;
         tx_reg       <= 1'b1;
      end else begin
         if (shift_load)
            shift_reg <= fifo_mem[rd_ptr_reg];
         else if (shift_en)
            shift_reg <= {1'b0, shift_reg[7:1]};
         if (bit_clr)
            bit_cnt_reg <= '0;
         else if (bit_inc)
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
         if (baud_load)
            baud_cnt_reg <= eff_div - 16'd1;
         else if (!baud_done)
            baud_cnt_reg <= baud_cnt_reg - 16'd1;
         tx_reg <= tx_next;
      end
   end

   assign tx_o = tx_reg;

   // ---------------- optional interrupt ----------------
   logic ctrl_bit;
`ifdef MMIO_UART_IRQ_EN
   logic irq_en_reg;
   logic irq_reg;

   // IRQ enable, and a level interrupt that drops right after an accepted push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_reg <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         if (wr_en && reg_off == 2'd3 && data_mem_we_i[0])
            irq_en_reg <= data_mem_write_i[0];
         irq_reg <= irq_en_reg & empty & ~busy & ~push_ok;
      end
   end

   assign ctrl_bit = irq_en_reg;
   assign irq_o    = irq_reg;
`else
   assign ctrl_bit = 1'b0;
`endif

   // ---------------- read path ----------------
   logic [31:0] rd_mux;
   logic [31:0] rdata_reg;

   // Register read mux. Reads never alter state.
   always_comb begin
      rd_mux = 32'd0;
      case (reg_off)
         2'd1:    rd_mux = {17'd0, 7'(count_reg), 4'd0, ovf_reg, busy, empty, full};
         2'd2:    rd_mux = {16'd0, div_reg};
         2'd3:    rd_mux = {31'd0, ctrl_bit};
         default: rd_mux = 32'd0;
      endcase
   end

   // Read data is registered one cycle after the address and is zero when the window is not selected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rdata_reg <= 32'd0;
      else
         rdata_reg <= sel ? rd_mux : 32'd0;
   end

   assign data_mem_read_o = rdata_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx using the default parameters.
// Expected values are hand-derived, and line waveforms are built from the 8N1 frame definition.
module tb_mmio_uart_tx;

   localparam logic [31:0] A_TX   = 32'h0000_1000;
   localparam logic [31:0] A_ST   = 32'h0000_1004;
   localparam logic [31:0] A_DIV  = 32'h0000_1008;
   localparam logic [31:0] A_CTRL = 32'h0000_100C;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;
`ifdef MMIO_UART_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mmio_uart_tx dut (
      .clk               (clk),
      .reset             (reset),
      .data_mem_we_i     (we),
      .data_mem_address_i(addr),
      .data_mem_write_i  (wdata),
      .data_mem_read_o   (rdata),
`ifdef MMIO_UART_IRQ_EN
      .irq_o             (irq),
`endif
      .tx_o              (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("check %s ok: %0h", tag, got);
      end
   endtask

   // Each bus task starts and ends on a falling edge.
   task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      addr  = a;
      we    = w;
      wdata = d;
      @(negedge clk);
      we    = 4'b0000;
      addr  = 32'd0;
      wdata = 32'd0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      we   = 4'b0000;
      @(negedge clk);
      d    = rdata;
      addr = 32'd0;
   endtask

   task automatic capture(input int n, output logic [127:0] w);
      w = '0;
      for (int i = 0; i < n; i++) begin
         w[i] = tx;
         @(negedge clk);
      end
   endtask

   // One 8N1 frame, with sample 0 in the LSB and bl cycles per bit.
   function automatic logic [127:0] frame(input logic [7:0] b, input int bl);
      logic [127:0] f;
      f = '0;
      for (int i = 0; i < 10 * bl; i++) begin
         int s;
         s = i / bl;
         if (s == 0)
            f[i] = 1'b0;
         else if (s == 9)
            f[i] = 1'b1;
         else
            f[i] = b[s-1];
      end
      return f;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0]  v;
      logic [127:0] w;
      reset = 1'b1;
      we    = 4'b0000;
      addr  = 32'd0;
      wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_rdata", rdata, 0);
      reset = 1'b0;

      // reset state
      rd(A_ST, v);   check("rst_status", v, 32'h2);
      rd(A_DIV, v);  check("rst_div", v, 868);
      rd(A_CTRL, v); check("rst_ctrl", v, 0);
      check("idle_tx", tx, 1);
`ifdef MMIO_UART_IRQ_EN
      check("irq_rst", irq, 0);
      wr(A_CTRL, 4'b0001, 32'h1);
      @(negedge clk);
      check("irq_on", irq, 1);
      rd(A_CTRL, v); check("ctrl_rb", v, 1);
`endif

      // divider byte lanes
      wr(A_DIV, 4'b0011, 32'h0000_0004);
      rd(A_DIV, v); check("div_write", v, 32'h4);
      wr(A_DIV, 4'b0010, 32'h0000_AB77);
      rd(A_DIV, v); check("div_hi_lane", v, 32'hAB04);
      wr(A_DIV, 4'b0011, 32'h0000_0004);

      // single frame 0x55 at 4 cycles per bit
      wr(A_TX, 4'b0001, 32'h55);
      check("pre_start_tx", tx, 1);
      @(negedge clk);
      capture(40, w);
      check("frame_55", w, frame(8'h55, 4));
      check("post_frame_tx", tx, 1);
      rd(A_ST, v); check("idle_after_55", v, 32'h2);

      // two frames back to back with no gap
      wr(A_TX, 4'b0001, 32'hA5);
      wr(A_TX, 4'b0001, 32'h3C);
      capture(80, w);
      check("b2b_frames", w, frame(8'hA5, 4) | (frame(8'h3C, 4) << 40));
      check("post_b2b_tx", tx, 1);
      rd(A_ST, v); check("idle_after_b2b", v, 32'h2);

      // DIV below 2 behaves as 2
      wr(A_DIV, 4'b0011, 32'h1);
      wr(A_TX, 4'b0001, 32'h3C);
      @(negedge clk);
      capture(20, w);
      check("frame_div1", w, frame(8'h3C, 2));

      // FIFO fill and overflow with the serializer stalled
      wr(A_DIV, 4'b0011, 32'hFFFF);
      wr(A_TX, 4'b0001, 32'h01);
      @(negedge clk);
      rd(A_ST, v); check("after_first_pop", v, 32'h6);
      for (int i = 0; i < 7; i++) wr(A_TX, 4'b0001, 32'h10 + i);
      rd(A_ST, v); check("count_depth_m1", v, 32'h0704);
      wr(A_TX, 4'b0001, 32'h20);
      rd(A_ST, v); check("full_set", v, 32'h0805);
      wr(A_TX, 4'b0001, 32'h21);
      rd(A_ST, v); check("overflow_set", v, 32'h080D);
      wr(A_ST, 4'b0001, 32'h8);
      rd(A_ST, v); check("overflow_clr", v, 32'h0805);

      // reset clears a full FIFO
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd(A_ST, v); check("rst_clears_fifo", v, 32'h2);

      // asynchronous reset during a DATA bit
      wr(A_DIV, 4'b0011, 32'h4);
      wr(A_TX, 4'b0001, 32'hA5);
      repeat (10) @(negedge clk);
      check("pre_reset_bit1", tx, 0);
      #2 reset = 1'b1;
      #1 check("async_reset_tx", tx, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd(A_ST, v);  check("mid_rst_status", v, 32'h2);
      rd(A_DIV, v); check("mid_rst_div", v, 868);
      capture(60, w);
      check("no_resume", w, {68'd0, {60{1'b1}}});

      // unselected address and wrong byte lane do not push
      wr(32'h0000_2000, 4'b0001, 32'h77);
      check("unsel_wr_rdata", rdata, 0);
      wr(A_TX, 4'b0010, 32'h7700);
      @(negedge clk);
      rd(A_ST, v); check("no_push", v, 32'h2);
      rd(32'h0000_2008, v); check("unsel_read", v, 0);
      rd(A_TX, v); check("txdata_reads0", v, 0);
      check("final_tx", tx, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
